fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Fetch front end of the 9-bit single-cycle core; sits directly upstream of the control decoder and register file.
- Owns the program counter, the Start/Ack run-state machine, branch/jump target selection, NOP injection while not running, the per-program cycle counter and a watchdog timeout.
- Drives the instruction ROM address and presents the active instruction to decode.

Parameters:
- PC_W, 10, program counter / ROM address width.
- IW, 9, instruction width.
- NOP, 9'h1FF, instruction presented to decode when not running.
- CNT_W, 16, cycle counter width.
- MAX_CYC, 16'hFFFF, watchdog limit in RUN cycles; 0 disables the watchdog.

Ports:
- Clk  in  1  clock, posedge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  testbench start request, level.
- InstIn  in  IW  instruction ROM data for InstAddr.
- AckReq  in  1  halt decoded by the control decoder (current instruction is a halt).
- BranchRelEn  in  1  conditional relative branch.
- BranchAbsEn  in  1  unconditional absolute jump.
- AluFlag  in  1  ALU zero flag (branch condition).
- Target  in  PC_W  branch offset (two's complement) or absolute target from the target LUT.
- InstAddr  out  PC_W  PC, to the instruction ROM.
- ActiveInst  out  IW  instruction to decode.
- Running  out  1  high in RUN.
- Ack  out  1  program-done flag to the testbench.
- Timeout  out  1  watchdog fired for the current program.
- CycleCount  out  CNT_W  RUN cycles of the current program.

Behaviour:
- States: IDLE, ARMED, RUN, DONE.
- Reset, synchronous, overrides everything including mid-RUN:
  - state=IDLE, PC=0, CycleCount=0, Timeout=0, Ack=0, Running=0.
  - ActiveInst=NOP.
- IDLE: Start=1 -> ARMED. PC is held.
- ARMED: PC is held. Start=0 -> RUN. Entering ARMED clears CycleCount and Timeout.
- RUN, every cycle:
  - ActiveInst=InstIn (combinational, same cycle as InstAddr).
  - CycleCount+=1; it saturates at all-ones and does not wrap.
- RUN, PC update (next PC):
  - BranchAbsEn=1 -> Target.
  - else BranchRelEn & AluFlag -> PC + Target. Target is sign-extended; the sum wraps modulo 2^PC_W.
  - else PC+1, wrapping modulo 2^PC_W.
  - BranchAbsEn and BranchRelEn both high: absolute jump wins.
- RUN, halt: AckReq=1 -> DONE. The PC does not advance (it stays on the halt). Branch inputs are ignored that cycle.
- RUN, watchdog: MAX_CYC != 0 and CycleCount reaches MAX_CYC-1 with no AckReq -> DONE with Timeout=1.
- RUN, Start=1: treated as a restart -> ARMED. PC is held and the in-flight instruction is replaced by NOP.
- DONE:
  - Ack=1 (registered: asserted on the first DONE cycle, held).
  - CycleCount frozen. PC held.
  - Start=1 -> ARMED with PC<=PC+1, so the next program begins after the halt.
- ActiveInst=NOP in every state except RUN. Decode therefore sees no writes or branches while not running.
- Running=1 only in RUN. Ack=1 only in DONE.
- Latency:
  - Start falling edge -> the first instruction reaches decode on the same cycle the FSM enters RUN; RUN begins one cycle after Start is sampled low in ARMED.
  - AckReq -> Ack: 1 cycle.
- AckReq and branch inputs are ignored outside RUN.

Decomposition:
- Shared package fetch_pkg holds:
  - typedef enum logic [1:0] fetch_state_t {IDLE, ARMED, RUN, DONE}.
  - localparam NOP_INST = 9'h1FF.
  - typedef logic [PC_W-1:0] pc_t.
- One natural sub-module: next_pc_sel, the combinational next-PC mux (hold / +1 / relative / absolute, with priority).
- The FSM, counter and watchdog stay in fetch_unit.

Test Plan:
- Reset then Start pulse 1 cycle, ROM of 4 non-branch instructions with AckReq at address 3:
  - InstAddr 0,1,2,3.
  - Ack rises the cycle after address 3.
  - CycleCount=4, Timeout=0.
- At PC=10, BranchRelEn=1, AluFlag=1, Target=10'h3FC (-4) -> next InstAddr=6. Same with AluFlag=0 -> next InstAddr=11.
- At PC=5, BranchAbsEn=1 and BranchRelEn=1, AluFlag=1, Target=200 -> next InstAddr=200. Relative branch from PC=1020 with Target=8 -> next InstAddr=4 (wrap).
- After DONE at PC=3, Start held high 3 cycles then released:
  - Ack drops on entering ARMED.
  - CycleCount clears to 0.
  - ActiveInst=NOP while Start is high.
  - First RUN InstAddr=4.
- MAX_CYC=8 with no halt in the program -> DONE after 8 RUN cycles, Timeout=1, Ack=1, CycleCount=8.
- Reset asserted mid-RUN at PC=7 -> next cycle PC=0, state IDLE, ActiveInst=NOP, Ack=0, and no PC advance until a new Start.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch front end.
//   fetch_state_t : run-state encoding (IDLE, ARMED, RUN, DONE)
//   NOP_INST      : instruction shown to decode while not running
//   pc_t          : program counter type at the default width
package fetch_pkg;
  localparam int PC_W = 10;
  localparam logic [8:0] NOP_INST = 9'h1FF;
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} fetch_state_t;
  typedef logic [PC_W-1:0] pc_t;
endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// next_pc_sel: next program counter mux, priority hold > absolute > taken relative > +1.
//   pc      : current program counter
//   adv     : PC may change this cycle (low holds the PC)
//   abs_en  : absolute jump to target
//   rel_en  : relative branch, taken when flag is set
//   flag    : branch condition
//   target  : absolute target or two's-complement offset
//   nxt     : next program counter
module next_pc_sel #(
  parameter int PC_W = 10
) (
  input  logic [PC_W-1:0] pc,
  input  logic            adv,
  input  logic            abs_en,
  input  logic            rel_en,
  input  logic            flag,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] nxt
);
  // Offset and PC share a width, so the modulo-2^PC_W sum is the sign-extended add.
  always_comb nxt = !adv ? pc : abs_en ? target : (rel_en && flag) ? pc + target : pc + 1'b1;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, Start/Ack run-state machine, NOP injection, cycle counter and watchdog.
//   Clk, Reset  : clock and synchronous active-high reset
//   Start       : start/restart request from the testbench
//   InstIn      : ROM data for InstAddr
//   AckReq      : current instruction is a halt
//   BranchRelEn, BranchAbsEn, AluFlag, Target : branch controls from decode/ALU
//   InstAddr    : program counter to the ROM
//   ActiveInst  : instruction to decode (NOP unless running)
//   Running, Ack, Timeout, CycleCount : run status
module fetch_unit #(
  parameter int              PC_W    = 10,
  parameter int              IW      = 9,
  parameter logic [IW-1:0]   NOP     = fetch_pkg::NOP_INST,
  parameter int              CNT_W   = 16,
  parameter logic [CNT_W-1:0] MAX_CYC = 16'hFFFF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [IW-1:0]    InstIn,
  input  logic             AckReq,
  input  logic             BranchRelEn,
  input  logic             BranchAbsEn,
  input  logic             AluFlag,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  InstAddr,
  output logic [IW-1:0]    ActiveInst,
  output logic             Running,
  output logic             Ack,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCount
);
  import fetch_pkg::*;
  localparam logic [CNT_W-1:0] WD_LIM = MAX_CYC - 1'b1;
  fetch_state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic to_q, to_d, run, adv, wd;
  // The PC moves on normal RUN cycles, and once when leaving DONE so the next program starts after the halt.
  next_pc_sel #(.PC_W(PC_W)) u_sel (
    .pc(pc_q), .adv(adv), .abs_en(BranchAbsEn && run), .rel_en(BranchRelEn && run),
    .flag(AluFlag), .target(Target), .nxt(pc_nxt)
  );
  always_comb begin
    run = state_q == RUN;
    wd = (MAX_CYC != '0) && (cnt_q == WD_LIM);
    adv = (run && !Start && !AckReq) || (state_q == DONE && Start);
    state_d = state_q;
    to_d = to_q;
    cnt_d = run ? cnt_q + (cnt_q != '1) : cnt_q;
    case (state_q)
      IDLE:  state_d = Start ? ARMED : IDLE;
      ARMED: state_d = Start ? ARMED : RUN;
      RUN: begin
        state_d = Start ? ARMED : (AckReq || wd) ? DONE : RUN;
        to_d = to_q || (!Start && !AckReq && wd);
      end
      DONE:  state_d = Start ? ARMED : DONE;
    endcase
    if (state_d == ARMED && state_q != ARMED) begin
      cnt_d = '0;
      to_d = 1'b0;
    end
    pc_d = Reset ? '0 : pc_nxt;
    if (Reset) begin
      state_d = IDLE;
      cnt_d = '0;
      to_d = 1'b0;
    end
  end
  always_ff @(posedge Clk) begin
    state_q <= state_d;
    pc_q <= pc_d;
    cnt_q <= cnt_d;
    to_q <= to_d;
  end
  // A restart request kills the in-flight instruction immediately.
  assign ActiveInst = (run && !Start) ? InstIn : NOP;
  assign InstAddr = pc_q;
  assign Running = run;
  assign Ack = state_q == DONE;
  assign Timeout = to_q;
  assign CycleCount = cnt_q;
endmodule
